lsu_ctrl: RTL and testbench

Load/store sequencer for the MEM stage. It takes one load or store per instruction from the pipeline and drives a single-port data memory through a req/ready handshake. It generates byte enables and splits accesses that cross a word boundary into two aligned word accesses. For loads, it merges the returned words, then sign- or zero-extends the result. While an access is in flight it stalls the pipeline.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_ctrl_if.sv | 20 ++
 rtl/lsu_extend.sv | 23 ++
 rtl/lsu_ctrl.sv | 126 ++++++++++++
 tb/tb_lsu_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and funct3 decode helpers for the MEM-stage load/store sequencer.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Access size in bytes; 0 flags an encoding with no load meaning.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return 3'd1;
            F3_LH, F3_LHU: return 3'd2;
            F3_LW:         return 3'd4;
            default:       return 3'd0;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW);
        return f3_size(f3) != 3'd0;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Single-port data memory bus: req/ready handshake driven by the sequencer.
interface lsu_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/lsu_extend.sv
// Load result formatter: right-align the addressed bytes of a two-word window, then extend.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [63:0] data,
    input  logic [1:0]  off,
    input  logic [2:0]  f3,
    output logic [31:0] result
);
    logic [31:0] sh;

    always_comb begin
        sh = 32'(data >> {off, 3'b000});
        case (f3)
            F3_LB:   result = {{24{sh[7]}}, sh[7:0]};
            F3_LH:   result = {{16{sh[15]}}, sh[15:0]};
            F3_LW:   result = sh;
            F3_LBU:  result = {24'b0, sh[7:0]};
            F3_LHU:  result = {16'b0, sh[15:0]};
            default: result = 32'b0;
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: byte lanes, word-crossing split, load merge/extend, pipeline stall.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_err,
    lsu_ctrl_if.master  mem
);
    lsu_state_t  state;
    logic [1:0]  off;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [63:0] sdata;
    logic [7:0]  be64;
    logic        split;
    logic [31:0] buf_lo;

    logic [2:0]  req_size;
    logic [3:0]  req_mask;
    logic [63:0] ext_in;
    logic [31:0] ext_out;
    logic        load_done;

    assign req_size = f3_size(funct3M);
    assign req_mask = (req_size == 3'd1) ? 4'b0001 :
                      (req_size == 3'd2) ? 4'b0011 : 4'b1111;

    // The extender sees the incoming word directly so the result can be registered into DONE.
    assign ext_in    = (state == S_ACC1) ? {mem.mem_rdata, buf_lo} : {32'b0, mem.mem_rdata};
    assign load_done = mem.mem_ready && !we &&
                       (((state == S_ACC0) && !split) || (state == S_ACC1));

    lsu_extend u_extend (
        .data   (ext_in),
        .off    (off),
        .f3     (f3),
        .result (ext_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            off        <= 2'b0;
            we         <= 1'b0;
            f3         <= 3'b0;
            base       <= 32'b0;
            sdata      <= 64'b0;
            be64       <= 8'b0;
            split      <= 1'b0;
            buf_lo     <= 32'b0;
            load_data  <= 32'b0;
            load_valid <= 1'b0;
            access_err <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            access_err <= 1'b0;
            case (state)
                S_IDLE: if (MemReqM) begin
                    off   <= ALUResultM[1:0];
                    we    <= MemWriteM;
                    f3    <= funct3M;
                    base  <= {ALUResultM[31:2], 2'b00};
                    sdata <= {32'b0, WriteDataM} << {ALUResultM[1:0], 3'b000};
                    be64  <= {4'b0, req_mask} << ALUResultM[1:0];
                    split <= ({2'b0, ALUResultM[1:0]} + {1'b0, req_size}) > 4'd4;
                    if (f3_legal(MemWriteM, funct3M)) begin
                        state <= S_ACC0;
                    end else begin
                        state      <= S_DONE;
                        access_err <= 1'b1;
                        load_data  <= 32'b0;
                    end
                end
                S_ACC0: if (mem.mem_ready) begin
                    buf_lo <= mem.mem_rdata;
                    state  <= split ? S_ACC1 : S_DONE;
                end
                S_ACC1: if (mem.mem_ready) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
            if (load_done) begin
                load_data  <= ext_out;
                load_valid <= 1'b1;
            end
        end
    end

    // Bus fields are pure functions of state and latched request, so they hold through wait cycles.
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = 32'b0;
        mem.mem_be    = 4'b0;
        mem.mem_wdata = 32'b0;
        case (state)
            S_ACC0: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = we;
                mem.mem_addr  = base;
                mem.mem_be    = we ? be64[3:0] : 4'b0;
                mem.mem_wdata = sdata[31:0];
            end
            S_ACC1: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = we;
                mem.mem_addr  = base + 32'd4;
                mem.mem_be    = we ? be64[7:4] : 4'b0;
                mem.mem_wdata = sdata[63:32];
            end
            default: ;
        endcase
    end

    assign StallM = ((state == S_IDLE) && MemReqM) || (state == S_ACC0) || (state == S_ACC1);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table of loads/stores plus wait-state and reset sequences.
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemReqM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallM, load_valid, access_err;
    logic [31:0] load_data;

    lsu_ctrl_if bus();

    lsu_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemReqM    (MemReqM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .StallM     (StallM),
        .load_data  (load_data),
        .load_valid (load_valid),
        .access_err (access_err),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rlo, rhi, a0, a1;
        logic [3:0]  be0, be1;
        logic [31:0] wd0, wd1, exp_data;
        logic        exp_err;
        int          n_acc;
    } vec_t;

    vec_t vecs[16];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic string nm(input int i, input string s);
        return $sformatf("v%0d_%s", i, s);
    endfunction

    task automatic run_vec(input int i, input vec_t v);
        int stalls, acc;
        bit done;
        stalls = 0; acc = 0; done = 0;
        @(negedge clk);
        MemReqM = 1'b1; MemWriteM = v.we; funct3M = v.f3;
        ALUResultM = v.addr; WriteDataM = v.wd; bus.mem_ready = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (c > 0) MemReqM = 1'b0;
            #1;
            bus.mem_ready = 1'b0;
            if (bus.mem_req) begin
                chk(nm(i, $sformatf("addr%0d", acc)), bus.mem_addr, acc == 0 ? v.a0 : v.a1);
                chk(nm(i, $sformatf("we%0d", acc)), 32'(bus.mem_we), 32'(v.we));
                chk(nm(i, $sformatf("be%0d", acc)), 32'(bus.mem_be), 32'(acc == 0 ? v.be0 : v.be1));
                if (v.we) chk(nm(i, $sformatf("wdata%0d", acc)), bus.mem_wdata, acc == 0 ? v.wd0 : v.wd1);
                bus.mem_ready = 1'b1;
                bus.mem_rdata = (acc == 0) ? v.rlo : v.rhi;
                acc++;
            end
            if (StallM) stalls++;
            else if (c > 0) begin
                chk(nm(i, "access_err"), 32'(access_err), 32'(v.exp_err));
                chk(nm(i, "load_valid"), 32'(load_valid), 32'(!v.we && !v.exp_err));
                if (!v.we) chk(nm(i, "load_data"), load_data, v.exp_data);
                done = 1'b1;
            end
            @(negedge clk);
        end
        chk(nm(i, "reached_done"), 32'(done), 32'd1);
        chk(nm(i, "accesses"), acc, v.n_acc);
        chk(nm(i, "stall_cycles"), stalls, v.exp_err ? 1 : v.n_acc + 1);
    endtask

    initial begin
        // we f3 addr wd rlo rhi a0 a1 be0 be1 wd0 wd1 exp_data exp_err n_acc
        vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 32'h100, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1};
        vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 32'h0, 32'h100, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'hFFFFFF80, 1'b0, 1};
        vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 32'h0, 32'h100, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h00000080, 1'b0, 1};
        vecs[3]  = '{1'b1, 3'b010, 32'h102, 32'h11223344, 32'h0, 32'h0, 32'h100, 32'h104, 4'hC, 4'h3, 32'h33440000, 32'h00001122, 32'h0, 1'b0, 2};
        vecs[4]  = '{1'b0, 3'b001, 32'h0FF, 32'h0, 32'hAB000000, 32'h000000CD, 32'h0FC, 32'h100, 4'h0, 4'h0, 32'h0, 32'h0, 32'hFFFFCDAB, 1'b0, 2};
        vecs[5]  = '{1'b0, 3'b101, 32'h0FF, 32'h0, 32'hAB000000, 32'h000000CD, 32'h0FC, 32'h100, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0000CDAB, 1'b0, 2};
        vecs[6]  = '{1'b1, 3'b000, 32'h201, 32'hFFFFFFA5, 32'h0, 32'h0, 32'h200, 32'h0, 4'h2, 4'h0, 32'hFFFFA500, 32'h0, 32'h0, 1'b0, 1};
        vecs[7]  = '{1'b1, 3'b001, 32'h003, 32'h0000BEEF, 32'h0, 32'h0, 32'h000, 32'h004, 4'h8, 4'h1, 32'hEF000000, 32'h000000BE, 32'h0, 1'b0, 2};
        vecs[8]  = '{1'b0, 3'b010, 32'h001, 32'h0, 32'h44332211, 32'h88776655, 32'h000, 32'h004, 4'h0, 4'h0, 32'h0, 32'h0, 32'h55443322, 1'b0, 2};
        vecs[9]  = '{1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h1234ABCD, 32'h00005678, 32'hFFFFFFFC, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h56781234, 1'b0, 2};
        vecs[10] = '{1'b0, 3'b000, 32'h202, 32'h0, 32'h00FE0000, 32'h0, 32'h200, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'hFFFFFFFE, 1'b0, 1};
        vecs[11] = '{1'b0, 3'b001, 32'h010, 32'h0, 32'h00007FFF, 32'h0, 32'h010, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h00007FFF, 1'b0, 1};
        vecs[12] = '{1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0};
        vecs[13] = '{1'b0, 3'b111, 32'h104, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0};
        vecs[14] = '{1'b1, 3'b100, 32'h108, 32'h55, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0};
        vecs[15] = '{1'b0, 3'b001, 32'h102, 32'h0, 32'h9ABC0000, 32'h0, 32'h100, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'hFFFF9ABC, 1'b0, 1};

        rst_n = 1'b0; MemReqM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010;
        ALUResultM = 32'h100; WriteDataM = 32'h0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_load_valid", 32'(load_valid), 32'd0);
        chk("rst_access_err", 32'(access_err), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_stall_follows_req", 32'(StallM), 32'd1);
        @(negedge clk);
        MemReqM = 1'b0; rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // mem_ready with no request outstanding must not start anything.
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1 chk("idle_ready_no_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk("idle_ready_stall", 32'(StallM), 32'd0);
        chk("idle_ready_valid", 32'(load_valid), 32'd0);

        // Store held in ACC0 for three wait cycles.
        @(negedge clk);
        MemReqM = 1'b1; MemWriteM = 1'b1; funct3M = 3'b010;
        ALUResultM = 32'h100; WriteDataM = 32'hCAFEF00D;
        #1 chk("ws_idle_stall", 32'(StallM), 32'd1);
        @(negedge clk);
        MemReqM = 1'b0;
        for (int w = 0; w < 4; w++) begin
            #1;
            chk($sformatf("ws_req_%0d", w), 32'(bus.mem_req), 32'd1);
            chk($sformatf("ws_addr_%0d", w), bus.mem_addr, 32'h100);
            chk($sformatf("ws_be_%0d", w), 32'(bus.mem_be), 32'hF);
            chk($sformatf("ws_wdata_%0d", w), bus.mem_wdata, 32'hCAFEF00D);
            chk($sformatf("ws_stall_%0d", w), 32'(StallM), 32'd1);
            if (w == 3) bus.mem_ready = 1'b1;
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
        #1;
        chk("ws_done_stall", 32'(StallM), 32'd0);
        chk("ws_done_no_valid", 32'(load_valid), 32'd0);

        // Load held in ACC0 for two wait cycles: no early load_valid.
        @(negedge clk);
        MemReqM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h104;
        @(negedge clk);
        MemReqM = 1'b0;
        for (int w = 0; w < 3; w++) begin
            #1;
            chk($sformatf("wl_valid_%0d", w), 32'(load_valid), 32'd0);
            chk($sformatf("wl_stall_%0d", w), 32'(StallM), 32'd1);
            if (w == 2) begin
                bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0BADF00D;
            end
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
        #1;
        chk("wl_done_valid", 32'(load_valid), 32'd1);
        chk("wl_done_data", load_data, 32'h0BADF00D);

        // Reset while the second half of a split load is outstanding.
        @(negedge clk);
        MemReqM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h001;
        @(negedge clk);
        MemReqM = 1'b0;
        #1;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h44332211;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk("rs_acc1_req", 32'(bus.mem_req), 32'd1);
        chk("rs_acc1_addr", bus.mem_addr, 32'h004);
        rst_n = 1'b0;
        #1;
        chk("rs_req_drop", 32'(bus.mem_req), 32'd0);
        chk("rs_addr_zero", bus.mem_addr, 32'd0);
        chk("rs_stall", 32'(StallM), 32'd0);
        chk("rs_valid", 32'(load_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(100, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end
endmodule
